// File: rtl/hc595_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : hc595_shifter
//  Brief    : Serialises a parallel word onto a 74HC595 chain (SER/SRCLK),
//             then pulses RCLK to latch it. Optional /OE drive: HC595_OE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module hc595_shifter #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_enable,
  output logic              o_ready,
  output logic              o_ser,
  output logic              o_srclk,
  output logic              o_rclk
`ifdef HC595_OE_EN
  ,
  output logic              o_oe_n
`endif
);

  localparam int c_DW = $clog2(CLK_DIV + 1);
  localparam int c_BW = $clog2(DATA_W + 1);
  localparam logic [c_DW-1:0] c_DIV_LAST  = c_DW'(CLK_DIV - 1);
  localparam logic [c_DW-1:0] c_DIV_ONE   = c_DW'(1);
  localparam logic [c_BW-1:0] c_BITS_INIT = c_BW'(DATA_W);
  localparam logic [c_BW-1:0] c_BITS_ONE  = c_BW'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LATCH    = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt, w_shreg_adv;
  logic [c_BW-1:0]   r_bits, w_bits_nxt;
  logic [c_DW-1:0]   r_div, w_div_nxt;
  logic              w_phase_done;
  logic              w_ser_nxt;
  logic              r_ready, r_ser, r_srclk, r_rclk;

  assign w_phase_done = (r_div == c_DIV_LAST);
  assign w_shreg_adv  = (MSB_FIRST != 0) ? (r_shreg << 1) : (r_shreg >> 1);
  assign w_ser_nxt    = (MSB_FIRST != 0) ? w_shreg_nxt[DATA_W-1] : w_shreg_nxt[0];

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_bits_nxt  = r_bits;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_state_nxt = ST_SHIFT_LO;
          w_shreg_nxt = i_data;
          w_bits_nxt  = c_BITS_INIT;
        end
      end
      ST_SHIFT_LO: begin
        if (w_phase_done) w_state_nxt = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (w_phase_done) begin
          w_shreg_nxt = w_shreg_adv;
          w_bits_nxt  = r_bits - c_BITS_ONE;
          w_state_nxt = (r_bits == c_BITS_ONE) ? ST_LATCH : ST_SHIFT_LO;
        end
      end
      ST_LATCH: begin
        if (w_phase_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Phase counter restarts on every state change; it never runs past the terminal count
    if (w_state_nxt != r_state || r_state == ST_IDLE)
      w_div_nxt = '0;
    else
      w_div_nxt = r_div + c_DIV_ONE;
  end

  // Outputs are registered from the next-state values so they line up with the state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_bits  <= '0;
      r_div   <= '0;
      r_ready <= 1'b1;
      r_ser   <= 1'b0;
      r_srclk <= 1'b0;
      r_rclk  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_bits  <= w_bits_nxt;
      r_div   <= w_div_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_srclk <= (w_state_nxt == ST_SHIFT_HI);
      r_rclk  <= (w_state_nxt == ST_LATCH);
      r_ser   <= (w_state_nxt == ST_SHIFT_LO || w_state_nxt == ST_SHIFT_HI) ? w_ser_nxt : 1'b0;
    end
  end

  assign o_ready = r_ready;
  assign o_ser   = r_ser;
  assign o_srclk = r_srclk;
  assign o_rclk  = r_rclk;

`ifdef HC595_OE_EN
  // Outputs stay tri-stated until a full word has been latched at least once
  logic r_oe_n;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_oe_n <= 1'b1;
    else if (r_state == ST_LATCH && w_phase_done)
      r_oe_n <= 1'b0;
  end

  assign o_oe_n = r_oe_n;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hc595_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hc595_shifter
//  Brief    : Directed bench for hc595_shifter with a behavioural 595 model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hc595_shifter;

  logic        clk = 1'b0;
  logic        rst, en, en2;
  logic [7:0]  data;
  logic [15:0] data2;
  logic        ready, ser, srclk, rclk, oe_n;
  logic        ready2, ser2, srclk2, rclk2;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  hc595_shifter #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_enable(en),
    .o_ready(ready), .o_ser(ser), .o_srclk(srclk), .o_rclk(rclk)
`ifdef HC595_OE_EN
    , .o_oe_n(oe_n)
`endif
  );

`ifndef HC595_OE_EN
  assign oe_n = 1'b0;
`else
  logic oe_n2;
`endif

  hc595_shifter #(.DATA_W(16), .CLK_DIV(1), .MSB_FIRST(0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(data2), .i_enable(en2),
    .o_ready(ready2), .o_ser(ser2), .o_srclk(srclk2), .o_rclk(rclk2)
`ifdef HC595_OE_EN
    , .o_oe_n(oe_n2)
`endif
  );

  // 595 behavioural model: shift on SRCLK rise, latch on RCLK rise; latched[7] is QH
  logic [7:0]  sr1 = 8'h00, latched = 8'h00, cap1 = 8'h00;
  logic [15:0] cap2 = 16'h0000;
  int          srk_rises = 0, rck_rises = 0, srk2_rises = 0;

  always @(posedge srclk) begin
    sr1 = {sr1[6:0], ser};
    cap1 = {cap1[6:0], ser};
    srk_rises++;
  end
  always @(posedge rclk) begin
    latched = sr1;
    rck_rises++;
  end
  always @(posedge srclk2) begin
    cap2 = {ser2, cap2[15:1]};
    srk2_rises++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer on dut: latency to ready, RCLK high cycles, latched value seen
  // just before RCLK rose, and /OE during the last RCLK-high cycle
  task automatic xfer(input logic [7:0] d, output int lat, output int rhigh,
                      output logic [7:0] pre, output logic oe_rclk);
    logic seen;
    en = 1'b1; data = d;
    tick();
    en = 1'b0; data = ~d;
    check("ready_low_after_enable", {31'd0, ready}, 32'd0);
    lat = 1; rhigh = 0; pre = latched; seen = 1'b0; oe_rclk = 1'bx;
    while (!ready && lat < 200) begin
      tick();
      lat++;
      if (rclk) begin
        rhigh++; seen = 1'b1; oe_rclk = oe_n;
      end else if (!seen) begin
        pre = latched;
      end
    end
  endtask

  int         lat, rhigh, base_s, base_r, c;
  logic [7:0] pre;
  logic       oe_r;

  initial begin
    rst = 1'b1; en = 1'b0; en2 = 1'b0; data = 8'h00; data2 = 16'h0000;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_outputs", {28'd0, ready, ser, srclk, rclk}, 32'h8);
    check("reset_outputs_dut2", {28'd0, ready2, ser2, srclk2, rclk2}, 32'h8);
`ifdef HC595_OE_EN
    check("reset_oe_n", {31'd0, oe_n}, 32'd1);
`endif

    // Abandoned transfer before any word has ever been latched
    en = 1'b1; data = 8'h3C;
    tick();
    en = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abandon_outputs", {28'd0, ready, ser, srclk, rclk}, 32'h8);
    check("abandon_no_rclk", rck_rises, 0);
`ifdef HC595_OE_EN
    check("abandon_oe_n", {31'd0, oe_n}, 32'd1);
`endif

    // Basic transfer of 0x55, MSB first
    base_s = srk_rises; base_r = rck_rises;
    xfer(8'h55, lat, rhigh, pre, oe_r);
    check("t1_ready_latency", lat, 69);
    check("t1_ser_bits", {24'd0, cap1}, 32'h55);
    check("t1_srclk_rises", srk_rises - base_s, 8);
    check("t1_rclk_pulses", rck_rises - base_r, 1);
    check("t1_rclk_width", rhigh, 4);
    check("t1_latched", {24'd0, latched}, 32'h55);
`ifdef HC595_OE_EN
    check("t1_oe_n_during_rclk", {31'd0, oe_r}, 32'd1);
    check("t1_oe_n_after", {31'd0, oe_n}, 32'd0);
`endif

    // Upstream replay: AA then 55, each visible only after its own RCLK
    xfer(8'hAA, lat, rhigh, pre, oe_r);
    check("t2_pre_aa", {24'd0, pre}, 32'h55);
    check("t2_latched_aa", {24'd0, latched}, 32'hAA);
    xfer(8'h55, lat, rhigh, pre, oe_r);
    check("t2_pre_55", {24'd0, pre}, 32'hAA);
    check("t2_latched_55", {24'd0, latched}, 32'h55);
`ifdef HC595_OE_EN
    check("t2_oe_n_stays", {31'd0, oe_n}, 32'd0);
`endif

    // Enable/data toggling while busy is ignored
    base_s = srk_rises; base_r = rck_rises;
    en = 1'b1; data = 8'h0F;
    tick();
    c = 1;
    while (!ready && c < 200) begin
      en = (c < 40) ? c[0] : 1'b0;
      data = 8'hFF;
      tick();
      c++;
    end
    en = 1'b0;
    check("t3_latency", c, 69);
    check("t3_latched", {24'd0, latched}, 32'h0F);
    repeat (20) tick();
    check("t3_one_rclk", rck_rises - base_r, 1);
    check("t3_srclk_rises", srk_rises - base_s, 8);
    check("t3_idle", {31'd0, ready}, 32'd1);

    // Reset during bit 5 of 0xC3
    base_s = srk_rises; base_r = rck_rises;
    en = 1'b1; data = 8'hC3;
    tick();
    en = 1'b0;
    repeat (42) tick();
    check("t4_bits_before_reset", srk_rises - base_s, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_outputs", {28'd0, ready, ser, srclk, rclk}, 32'h8);
    check("t4_latched_kept", {24'd0, latched}, 32'h0F);
    check("t4_no_rclk", rck_rises - base_r, 0);
`ifdef HC595_OE_EN
    check("t4_oe_n_reset", {31'd0, oe_n}, 32'd1);
`endif

    // Reset and enable on the same edge: no transfer
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    tick();
    check("rst_en_same_edge_ready", {31'd0, ready}, 32'd1);
    repeat (10) tick();
    check("rst_en_same_edge_no_shift", srk_rises - base_s, 5);

    // dut2: 16 bits, CLK_DIV=1, LSB first, enable held high
    base_s = srk2_rises;
    en2 = 1'b1; data2 = 16'h8001;
    tick();
    check("t5_ready_low", {31'd0, ready2}, 32'd0);
    for (int j = 0; j < 3; j++) begin
      c = 0;
      while (!ready2 && c < 200) begin
        tick();
        c++;
      end
      check("t5_busy_cycles", c, 33);
      check("t5_srclk_rises", srk2_rises - base_s, 16 * (j + 1));
      check("t5_word", {16'd0, cap2}, (j == 2) ? 32'h1234 : 32'h8001);
      if (j == 1) data2 = 16'h1234;
      if (j == 2) en2 = 1'b0;
      tick();
      check("t5_ready_one_cycle", {31'd0, ready2}, (j == 2) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
